// File: rtl/decode_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : decode_rom_loader
//  Description : Byte-stream writer for the decode-stage microinstruction
//                store. Assembles little-endian bytes into WORD_W-bit words,
//                writes them at consecutive addresses and checks a trailing
//                mod-256 checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_rom_loader #(
  parameter int WORD_W = 44,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        checksum_o
);

  localparam int NBYTES = (WORD_W + 7) / 8;
  localparam int LAST_W = WORD_W - 8 * (NBYTES - 1);
  localparam int BIDX_W = $clog2(NBYTES);
  localparam int ASM_W  = 8 * (NBYTES - 1);

  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_CSUM  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        sum_w;

  // Running sum including the byte currently on the bus
  assign sum_w = csum_q + in_data_i;

  // Next-state logic for the load sequence
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    asm_d        = asm_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    csum_d       = csum_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (word_count_i == '0 || word_count_i > C_DEPTH) begin
            // Illegal length: flag it without ever becoming busy
            err_d = 1'b1;
          end else begin
            err_d        = 1'b0;
            csum_d       = 8'h00;
            busy_d       = 1'b1;
            addr_d       = base_addr_i;
            words_left_d = word_count_i;
            byte_idx_d   = '0;
            state_d      = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          csum_d = sum_w;
          if (byte_idx_q == BIDX_W'(NBYTES - 1)) begin
            // Last byte only contributes its low bits to the word
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = {in_data_i[LAST_W-1:0], asm_q};
            byte_idx_d = '0;
            state_d    = S_WRITE;
          end else begin
            asm_d[8*byte_idx_q +: 8] = in_data_i;
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        addr_d       = addr_q + 1'b1;
        words_left_d = words_left_q - 1'b1;
        state_d      = (words_left_q == (ADDR_W+1)'(1)) ? S_CSUM : S_LOAD;
      end
      S_CSUM: begin
        // The checksum byte itself is not folded into the reported sum
        if (in_valid_i) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (sum_w == 8'h00) done_d = 1'b1;
          else                err_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      asm_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      csum_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      asm_q        <= asm_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      csum_q       <= csum_d;
    end
  end

  assign in_ready_o = (state_q == S_LOAD) || (state_q == S_CSUM);
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign checksum_o = csum_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_rom_loader
//  Description : Directed self-checking bench for decode_rom_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_rom_loader;

  localparam int WORD_W = 44;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        checksum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [WORD_W-1:0] wd_q[$];
  int                wc_q[$];
  logic [7:0]        tx[$];

  decode_rom_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .checksum_o   (checksum)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure write spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Record every store write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] word_of(input int w);
    return {tx[w*6+5][3:0], tx[w*6+4], tx[w*6+3], tx[w*6+2], tx[w*6+1], tx[w*6]};
  endfunction

  function automatic logic [7:0] sum_of(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + tx[i];
    return s;
  endfunction

  // Fill tx with words*6 payload bytes plus a checksum byte (good or off by one)
  task automatic build(input int words, input int seed, input bit good);
    logic [7:0] s;
    tx.delete();
    for (int i = 0; i < words * 6; i++) tx.push_back(8'((seed + 37 * i) & 255));
    s = sum_of(words * 6);
    tx.push_back(good ? 8'(-s) : 8'(8'h01 - s));
  endtask

  task automatic send_bytes(input int first, input int n, input bit gaps);
    int guard;
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = 8'hXX;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = tx[i];
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check_eq("in_ready_wait", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic do_start(input int base, input int cnt);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = ADDR_W'(base);
    word_count = (ADDR_W+1)'(cnt);
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, in_ready, 0);
    check_eq({tag, "_wr_en"}, wr_en, 0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_csum"}, checksum, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_data = 8'h00; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // 1: single word, explicit bytes; payload sum 0x05 so good checksum is 0xFB
    clear_log();
    tx.delete();
    tx.push_back(8'h01); tx.push_back(8'h02); tx.push_back(8'h03);
    tx.push_back(8'h04); tx.push_back(8'h05); tx.push_back(8'hF6);
    tx.push_back(8'hFB);
    do_start(0, 1);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ready", in_ready, 1);
    send_bytes(0, 7, 0);
    check_eq("t1_done", done, 1);
    check_eq("t1_err", err, 0);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_csum", checksum, 8'h05);
    check_eq("t1_nwr", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      check_eq("t1_addr", wa_q[0], 0);
      check_eq("t1_data", wd_q[0], 44'h605_0403_0201);
    end
    @(negedge clk);
    check_eq("t1_done_pulse", done, 0);
    check_eq("t1_hold_data", wr_data, 44'h605_0403_0201);

    // 2: three words wrapping past the top address, valid held high
    clear_log();
    build(3, 8'h20, 1);
    do_start(1022, 3);
    send_bytes(0, 19, 0);
    check_eq("t2_done", done, 1);
    check_eq("t2_csum", checksum, sum_of(18));
    check_eq("t2_nwr", wa_q.size(), 3);
    if (wa_q.size() == 3) begin
      check_eq("t2_addr0", wa_q[0], 1022);
      check_eq("t2_addr1", wa_q[1], 1023);
      check_eq("t2_addr2", wa_q[2], 0);
      for (int w = 0; w < 3; w++) check_eq("t2_data", wd_q[w], word_of(w));
      check_eq("t2_gap01", wc_q[1] - wc_q[0], 7);
      check_eq("t2_gap12", wc_q[2] - wc_q[1], 7);
    end

    // 3: bad checksum sets sticky err; next good start clears it
    clear_log();
    tx[6] = 8'hFC;
    tx.delete();
    tx.push_back(8'h01); tx.push_back(8'h02); tx.push_back(8'h03);
    tx.push_back(8'h04); tx.push_back(8'h05); tx.push_back(8'hF6);
    tx.push_back(8'hFC);
    do_start(0, 1);
    send_bytes(0, 7, 0);
    check_eq("t3_err", err, 1);
    check_eq("t3_done", done, 0);
    check_eq("t3_busy", busy, 0);
    check_eq("t3_nwr", wa_q.size(), 1);
    repeat (2) @(negedge clk);
    check_eq("t3_err_sticky", err, 1);
    check_eq("t3_done_late", done, 0);
    tx[6] = 8'hFB;
    do_start(0, 1);
    check_eq("t3_err_clr", err, 0);
    send_bytes(0, 7, 0);
    check_eq("t3_done2", done, 1);

    // 4: illegal lengths
    clear_log();
    do_start(5, 0);
    check_eq("t4_err0", err, 1);
    check_eq("t4_busy0", busy, 0);
    check_eq("t4_ready0", in_ready, 0);
    do_start(5, 1025);
    check_eq("t4_err1025", err, 1);
    check_eq("t4_busy1025", busy, 0);
    repeat (10) @(negedge clk);
    check_eq("t4_nwr", wa_q.size(), 0);

    // 5: reset in the middle of word 2
    clear_log();
    build(4, 8'h33, 1);
    do_start(5, 4);
    send_bytes(0, 9, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t5");
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t5_nwr", wa_q.size(), 1);
    clear_log();
    build(1, 8'h47, 1);
    do_start(100, 1);
    send_bytes(0, 7, 0);
    check_eq("t5_done", done, 1);
    check_eq("t5_nwr2", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      check_eq("t5_addr", wa_q[0], 100);
      check_eq("t5_data", wd_q[0], word_of(0));
    end

    // 6: gapped stream with an ignored second start mid-load
    clear_log();
    build(2, 8'h5A, 1);
    do_start(200, 2);
    send_bytes(0, 3, 1);
    do_start(7, 5);
    check_eq("t6_busy", busy, 1);
    send_bytes(3, 10, 1);
    check_eq("t6_done", done, 1);
    check_eq("t6_err", err, 0);
    check_eq("t6_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check_eq("t6_addr0", wa_q[0], 200);
      check_eq("t6_addr1", wa_q[1], 201);
      check_eq("t6_data0", wd_q[0], word_of(0));
      check_eq("t6_data1", wd_q[1], word_of(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
